pmp_scan_ctrl: RTL and testbench
================================

// Module: pmp_scan_ctrl
// PURPOSE
//  Sequential PMP checker controller. Accepts one access request at a time and scans NUM_ENTRIES
//  entries serially, one per cycle, through a single shared address-match unit. The lowest-numbered
//  matching entry decides the result, otherwise the privilege default applies. Sits between the
//  LSU/fetch request path and the CSR-held pmpcfg/pmpaddr arrays, and returns allow/fault.
// PARAMETERS
//  NUM_ENTRIES  16  number of PMP entries scanned (2..64)
//  IDX_W        $clog2(NUM_ENTRIES)  derived; width of entry index
// PORTS
//  clk          in   1                 single clock, all state on rising edge
//  rst_n        in   1                 synchronous, active-low reset
//  req_valid    in   1                 access request present
//  req_ready    out  1                 controller can accept (IDLE only)
//  req_addr     in   32                physical byte address
//  req_type     in   2                 0=R, 1=W, 2=X (3 is reserved and is denied)
//  req_mmode    in   1                 1 = machine mode, 0 = S/U mode
//  pmpcfg_i     in   8*NUM_ENTRIES     entry i = [8i+7:8i]; bit0 R, 1 W, 2 X, [4:3] A, 7 L
//  pmpaddr_i    in   32*NUM_ENTRIES    entry i = [32i+31:32i]; holds addr[33:2]
//  resp_valid   out  1                 result valid, held until accepted
//  resp_ready   in   1                 consumer accepts result
//  resp_allow   out  1                 1 = access permitted
//  resp_hit     out  1                 1 = an entry matched
//  resp_idx     out  IDX_W             matching entry index (0 when resp_hit=0)
// BEHAVIOUR
//  - Reset (rst_n=0 at an edge): state=IDLE. resp_valid, resp_allow, resp_hit and resp_idx are 0.
//    req_ready=1 from the first cycle after reset. A reset mid-scan or mid-response discards the request.
//  - FSM IDLE -> SCAN -> RESP -> IDLE.
//    IDLE: req_ready=1. On req_valid, latch addr/type/mmode, set idx=0 and go to SCAN.
//    SCAN: evaluate entry idx. On a match, latch idx and permissions and go to RESP.
//          Else, if idx==NUM_ENTRIES-1, go to RESP with no hit. Else idx++.
//    RESP: resp_valid=1 with outputs stable. When resp_ready=1, go to IDLE. req_ready=0.
//  - Latency: accept at cycle 0; entry k is evaluated at cycle k+1; a match at k gives
//    resp_valid at cycle k+2. No hit gives resp_valid at cycle NUM_ENTRIES+1.
//  - Address match (A field): 0 OFF never matches. Compare a = addr[31:2] with p = pmpaddr[i][29:0].
//    1 TOR:   pmpaddr[i-1][29:0] <= a < p; entry 0 uses lower bound 0. Unsigned compare.
//             Lower bound >= upper bound gives no match.
//    2 NA4:   a == p.
//    3 NAPOT: t = count of trailing ones of p; match iff a[29:t+1] == p[29:t+1].
//             p all ones matches everything.
//  - Permission (perm = cfg bit selected by req_type; type 3 -> perm=0):
//    hit, S/U:   allow = perm.
//    hit, M:     allow = ~L | perm.
//    no hit, M:  allow=1.
//    no hit, S/U: allow=0.
//    Reserved combination R=0,W=1 gives perm=0 for both R and W.
//  - pmpcfg_i/pmpaddr_i are read live each SCAN cycle, not snapshotted. A change to entry j takes
//    effect only if j >= idx at the cycle of the change. CSR logic stalls writes while req_ready=0.
//  - Request fields are latched at accept; req_addr changes afterwards are ignored.
// STRUCTURE
//  - Package pmp_pkg: enum a_mode_e {OFF,TOR,NA4,NAPOT}; enum acc_e {ACC_R,ACC_W,ACC_X};
//    cfg bit-position constants CFG_R/W/X/L and CFG_A_LO/HI; state enum {IDLE,SCAN,RESP}.
//  - One sub-module pmp_addr_match: combinational. Inputs addr[31:2], pmpaddr_cur, pmpaddr_prev,
//    a_mode. Output match. Instantiated once and fed by a mux on idx.
//  - Top level holds the FSM, idx counter, request latch and result registers.
// TESTING
//  1 Reset mid-scan: rst_n=0 at cycle 3 of a scan -> next cycle resp_valid=0, req_ready=1,
//    and no response is ever produced for that request.
//  2 NA4 at entry 2: pmpaddr2=0x0000_0400, cfg2=0x13 (A=NA4, R,W); S-mode W to 0x1000
//    -> resp_valid at cycle 4, allow=1, hit=1, idx=2. Same setup with X -> allow=0.
//  3 TOR: pmpaddr0=0x400, pmpaddr1=0x800, cfg1=0x0D (A=TOR, R,X); U-mode R to 0x1FFC
//    -> allow=1, idx=1. R to 0x2000 -> no hit, allow=0 at cycle NUM_ENTRIES+1.
//  4 NAPOT + priority: pmpaddr0=0x1FF (4 KiB at 0), cfg0=0x18 (NAPOT, no perms);
//    entry 1 NAPOT covers all, RWX. S-mode R to 0x0800 -> hit idx=0, allow=0.
//    M-mode R -> allow=1 (L=0). Set cfg0 L bit (0x98) -> M-mode R gives allow=0.
//  5 Handshake: hold resp_ready=0 for 5 cycles -> resp_* stable and req_ready=0 throughout.
//    A req_valid pulse in that window is not accepted. After resp_ready=1, the next request
//    is accepted in IDLE on the following cycle.
//  6 All entries OFF: M-mode W -> hit=0, allow=1. S-mode W -> allow=0. req_type=3 on a hit
//    with RWX -> allow=0.

Source files
------------

// File: rtl/pmp_pkg.sv
// rtl/pmp_pkg.sv - shared types and cfg field positions for the PMP scan controller
package pmp_pkg;

    localparam int CFG_R    = 0;
    localparam int CFG_W    = 1;
    localparam int CFG_X    = 2;
    localparam int CFG_A_LO = 3;
    localparam int CFG_A_HI = 4;
    localparam int CFG_L    = 7;

    typedef enum logic [1:0] {OFF = 2'd0, TOR = 2'd1, NA4 = 2'd2, NAPOT = 2'd3} a_mode_e;
    typedef enum logic [1:0] {ACC_R = 2'd0, ACC_W = 2'd1, ACC_X = 2'd2} acc_e;
    typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, RESP = 2'd2} state_e;

    // W without R is reserved, so write permission also requires R
    function automatic logic perm_bit(input logic [7:0] cfg, input logic [1:0] typ);
        logic p;
        case (typ)
            2'd0:    p = cfg[CFG_R];
            2'd1:    p = cfg[CFG_W] & cfg[CFG_R];
            2'd2:    p = cfg[CFG_X];
            default: p = 1'b0;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/pmp_addr_match.sv
// rtl/pmp_addr_match.sv - combinational address match for one PMP entry
module pmp_addr_match
    import pmp_pkg::*;
(
    input  logic [31:2] addr,
    input  logic [31:0] pmpaddr_cur,
    input  logic [31:0] pmpaddr_prev,
    input  a_mode_e     a_mode,
    output logic        match
);

    logic [29:0] a;
    logic [29:0] p;
    logic [29:0] lo;
    logic [29:0] ones_mask;
    logic        unused_hi;

    assign a         = addr;
    assign p         = pmpaddr_cur[29:0];
    assign lo        = pmpaddr_prev[29:0];
    // Trailing-ones run of p plus the first zero above it; all ones when p is all ones
    assign ones_mask = p ^ (p + 30'd1);
    assign unused_hi = ^{pmpaddr_cur[31:30], pmpaddr_prev[31:30]};

    always_comb begin
        match = 1'b0;
        case (a_mode)
            TOR:     match = (a >= lo) && (a < p);
            NA4:     match = (a == p);
            NAPOT:   match = (((a ^ p) & ~ones_mask) == 30'd0);
            default: match = 1'b0;
        endcase
    end

endmodule

// File: rtl/pmp_scan_ctrl.sv
// rtl/pmp_scan_ctrl.sv - serial PMP checker: one entry per cycle, lowest match wins
module pmp_scan_ctrl
    import pmp_pkg::*;
#(
    parameter int NUM_ENTRIES = 16,
    parameter int IDX_W       = $clog2(NUM_ENTRIES)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [31:0]              req_addr,
    input  logic [1:0]               req_type,
    input  logic                     req_mmode,
    input  logic [8*NUM_ENTRIES-1:0] pmpcfg_i,
    input  logic [32*NUM_ENTRIES-1:0] pmpaddr_i,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic                     resp_allow,
    output logic                     resp_hit,
    output logic [IDX_W-1:0]         resp_idx
);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [29:0]        addr_q, addr_d;
    logic [1:0]         type_q, type_d;
    logic               mmode_q, mmode_d;
    logic               allow_q, allow_d;
    logic               hit_q, hit_d;
    logic [IDX_W-1:0]   ridx_q, ridx_d;

    logic [31:0]        addr_arr [NUM_ENTRIES];
    logic [7:0]         cfg_arr  [NUM_ENTRIES];
    logic [31:0]        prev_addr;
    logic [7:0]         cfg_cur;
    logic               match;
    logic               unused_lsb;

    always_comb begin
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            addr_arr[i] = pmpaddr_i[32*i +: 32];
            cfg_arr[i]  = pmpcfg_i[8*i +: 8];
        end
    end

    // Entry 0 of a TOR range starts at address 0
    assign prev_addr  = (idx_q == '0) ? 32'd0 : addr_arr[idx_q - IDX_W'(1)];
    assign cfg_cur    = cfg_arr[idx_q];
    assign unused_lsb = ^req_addr[1:0];

    pmp_addr_match u_match (
        .addr         (addr_q),
        .pmpaddr_cur  (addr_arr[idx_q]),
        .pmpaddr_prev (prev_addr),
        .a_mode       (a_mode_e'(cfg_cur[CFG_A_HI:CFG_A_LO])),
        .match        (match)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        addr_d  = addr_q;
        type_d  = type_q;
        mmode_d = mmode_q;
        allow_d = allow_q;
        hit_d   = hit_q;
        ridx_d  = ridx_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    addr_d  = req_addr[31:2];
                    type_d  = req_type;
                    mmode_d = req_mmode;
                    idx_d   = '0;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (match) begin
                    hit_d   = 1'b1;
                    ridx_d  = idx_q;
                    allow_d = perm_bit(cfg_cur, type_q) | (mmode_q & ~cfg_cur[CFG_L]);
                    state_d = RESP;
                end else if (idx_q == IDX_W'(NUM_ENTRIES - 1)) begin
                    hit_d   = 1'b0;
                    ridx_d  = '0;
                    allow_d = mmode_q;
                    state_d = RESP;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            addr_q  <= '0;
            type_q  <= '0;
            mmode_q <= 1'b0;
            allow_q <= 1'b0;
            hit_q   <= 1'b0;
            ridx_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            addr_q  <= addr_d;
            type_q  <= type_d;
            mmode_q <= mmode_d;
            allow_q <= allow_d;
            hit_q   <= hit_d;
            ridx_q  <= ridx_d;
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = (state_q == RESP);
    assign resp_allow = allow_q;
    assign resp_hit   = hit_q;
    assign resp_idx   = ridx_q;

endmodule

// File: tb/tb_pmp_scan_ctrl.sv
// tb/tb_pmp_scan_ctrl.sv - directed self-checking bench for pmp_scan_ctrl
module tb_pmp_scan_ctrl;

    localparam int N = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              req_valid;
    logic              req_ready;
    logic [31:0]       req_addr;
    logic [1:0]        req_type;
    logic              req_mmode;
    logic [8*N-1:0]    pmpcfg;
    logic [32*N-1:0]   pmpaddr;
    logic              resp_valid;
    logic              resp_ready;
    logic              resp_allow;
    logic              resp_hit;
    logic [3:0]        resp_idx;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pmp_scan_ctrl #(.NUM_ENTRIES(N)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_type   (req_type),
        .req_mmode  (req_mmode),
        .pmpcfg_i   (pmpcfg),
        .pmpaddr_i  (pmpaddr),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_allow (resp_allow),
        .resp_hit   (resp_hit),
        .resp_idx   (resp_idx)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_resp(output int lat);
        lat = 0;
        while (lat < 100) begin
            @(negedge clk);
            lat++;
            if (resp_valid) break;
        end
    endtask

    task automatic start_req(input logic [31:0] addr, input logic [1:0] typ, input logic mm);
        @(negedge clk);
        req_valid = 1'b1;
        req_addr  = addr;
        req_type  = typ;
        req_mmode = mm;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_addr  = 32'hDEAD_BEEC;
    endtask

    task automatic run(input string tag, input logic [31:0] addr, input logic [1:0] typ,
                       input logic mm, input int exp_lat, input logic exp_hit,
                       input logic exp_allow, input int exp_idx);
        int lat;
        @(negedge clk);
        chk({tag, "_rdy"}, 32'(req_ready), 32'd1);
        start_req(addr, typ, mm);
        wait_resp(lat);
        chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_hit"}, 32'(resp_hit), 32'(exp_hit));
        chk({tag, "_allow"}, 32'(resp_allow), 32'(exp_allow));
        chk({tag, "_idx"}, 32'(resp_idx), 32'(exp_idx));
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        @(negedge clk);
        chk({tag, "_done_valid"}, 32'(resp_valid), 32'd0);
        chk({tag, "_done_rdy"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        int lat;
        logic saw;
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_addr   = '0;
        req_type   = '0;
        req_mmode  = 1'b0;
        resp_ready = 1'b0;
        pmpcfg     = '0;
        pmpaddr    = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", 32'(resp_valid), 32'd0);
        chk("rst_allow", 32'(resp_allow), 32'd0);
        chk("rst_hit", 32'(resp_hit), 32'd0);
        chk("rst_idx", 32'(resp_idx), 32'd0);
        chk("rst_rdy", 32'(req_ready), 32'd1);
        rst_n = 1'b1;

        // NA4 at entry 2
        pmpaddr[2*32 +: 32] = 32'h0000_0400;
        pmpcfg[2*8 +: 8]    = 8'h13;
        run("na4_w", 32'h1000, 2'd1, 1'b0, 4, 1'b1, 1'b1, 2);
        run("na4_x", 32'h1000, 2'd2, 1'b0, 4, 1'b1, 1'b0, 2);

        // TOR at entry 1 bounded by entry 0
        pmpcfg  = '0;
        pmpaddr = '0;
        pmpaddr[0*32 +: 32] = 32'h400;
        pmpaddr[1*32 +: 32] = 32'h800;
        pmpcfg[1*8 +: 8]    = 8'h0D;
        run("tor_in", 32'h1FFC, 2'd0, 1'b0, 3, 1'b1, 1'b1, 1);
        run("tor_out", 32'h2000, 2'd0, 1'b0, N + 1, 1'b0, 1'b0, 0);

        // NAPOT with priority over a covering entry
        pmpcfg  = '0;
        pmpaddr = '0;
        pmpaddr[0*32 +: 32] = 32'h1FF;
        pmpcfg[0*8 +: 8]    = 8'h18;
        pmpaddr[1*32 +: 32] = 32'h3FFF_FFFF;
        pmpcfg[1*8 +: 8]    = 8'h1F;
        run("napot_s", 32'h0800, 2'd0, 1'b0, 2, 1'b1, 1'b0, 0);
        run("napot_m", 32'h0800, 2'd0, 1'b1, 2, 1'b1, 1'b1, 0);
        run("napot_all", 32'h1000, 2'd0, 1'b0, 3, 1'b1, 1'b1, 1);
        pmpcfg[0*8 +: 8] = 8'h98;
        run("napot_lock", 32'h0800, 2'd0, 1'b1, 2, 1'b1, 1'b0, 0);

        // Response held while resp_ready is low; request pulse ignored
        start_req(32'h0800, 2'd0, 1'b1);
        wait_resp(lat);
        chk("hs_lat", 32'(lat), 32'd2);
        for (int i = 0; i < 5; i++) begin
            chk("hs_valid", 32'(resp_valid), 32'd1);
            chk("hs_allow", 32'(resp_allow), 32'd0);
            chk("hs_hit", 32'(resp_hit), 32'd1);
            chk("hs_idx", 32'(resp_idx), 32'd0);
            chk("hs_rdy", 32'(req_ready), 32'd0);
            if (i == 1) begin
                req_valid = 1'b1;
                req_addr  = 32'h1000;
                req_mmode = 1'b0;
            end else begin
                req_valid = 1'b0;
            end
            @(negedge clk);
        end
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        @(negedge clk);
        chk("hs_idle_rdy", 32'(req_ready), 32'd1);
        chk("hs_idle_valid", 32'(resp_valid), 32'd0);
        @(negedge clk);
        chk("hs_no_accept", 32'(req_ready), 32'd1);
        run("hs_next", 32'h1000, 2'd0, 1'b0, 3, 1'b1, 1'b1, 1);

        // All entries off, reserved type and reserved W-only encoding
        pmpcfg  = '0;
        pmpaddr = '0;
        run("off_m", 32'h4000, 2'd1, 1'b1, N + 1, 1'b0, 1'b1, 0);
        run("off_s", 32'h4000, 2'd1, 1'b0, N + 1, 1'b0, 1'b0, 0);
        pmpaddr[0*32 +: 32] = 32'h3FFF_FFFF;
        pmpcfg[0*8 +: 8]    = 8'h1F;
        run("type3", 32'h4000, 2'd3, 1'b0, 2, 1'b1, 1'b0, 0);
        run("rwx_w", 32'h4000, 2'd1, 1'b0, 2, 1'b1, 1'b1, 0);
        pmpcfg[0*8 +: 8] = 8'h1A;
        run("wonly_w", 32'h4000, 2'd1, 1'b0, 2, 1'b1, 1'b0, 0);
        run("wonly_r", 32'h4000, 2'd0, 1'b0, 2, 1'b1, 1'b0, 0);

        // Reset during a scan discards the request
        pmpcfg  = '0;
        pmpaddr = '0;
        start_req(32'h4000, 2'd0, 1'b1);
        repeat (3) @(negedge clk);
        chk("mid_scanning", 32'(resp_valid), 32'd0);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_valid", 32'(resp_valid), 32'd0);
        chk("mid_rst_rdy", 32'(req_ready), 32'd1);
        rst_n = 1'b1;
        saw = 1'b0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            saw = saw | resp_valid;
        end
        chk("mid_no_resp", 32'(saw), 32'd0);
        chk("mid_idle_rdy", 32'(req_ready), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
